// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and sizes for the register-file write-port arbiter and its
// mul/div result queue.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W       = 5;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned MDQ_DEPTH        = 2;
  localparam int unsigned MDQ_CNT_W        = 2;

  typedef struct packed {
    logic                  valid;
    logic                  kill;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } mdq_entry_t;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_HEAD = 2'd2
  } grant_e;

  // Entry still owns a future write to addr (register 0 never pending).
  function automatic logic entry_pending(input mdq_entry_t e,
                                         input logic [REG_ADDR_W-1:0] addr);
    return e.valid && !e.kill && (addr != '0) && (e.rd == addr);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the WB stage / mul-div unit / hazard unit and the arbiter.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic                  RegWrite_WB;
  logic [REG_ADDR_W-1:0] WriteReg_WB;
  logic [DATA_W-1:0]     WriteReg_Data_WB;

  logic                  md_valid;
  logic [REG_ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0]     md_data;
  logic                  md_ready;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  stall_wb;

  logic [REG_ADDR_W-1:0] query_rs;
  logic [REG_ADDR_W-1:0] query_rt;
  logic                  pend_rs;
  logic                  pend_rt;

  modport slave (
    input  RegWrite_WB, WriteReg_WB, WriteReg_Data_WB,
    input  md_valid, md_rd, md_data,
    output md_ready,
    output rf_we, rf_waddr, rf_wdata, stall_wb,
    input  query_rs, query_rt,
    output pend_rs, pend_rt
  );

  modport master (
    output RegWrite_WB, WriteReg_WB, WriteReg_Data_WB,
    output md_valid, md_rd, md_data,
    input  md_ready,
    input  rf_we, rf_waddr, rf_wdata, stall_wb,
    output query_rs, query_rt,
    input  pend_rs, pend_rt
  );

endinterface

// File: rtl/wb_md_queue.sv
// Two-entry in-order queue of mul/div results with kill-by-address and
// pending-write lookup for the hazard unit. Slot 0 is always the head.
module wb_md_queue
  import wb_port_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_rd_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  input  logic                  kill_en_i,
  input  logic [REG_ADDR_W-1:0] kill_addr_i,
  input  logic [REG_ADDR_W-1:0] query_rs_i,
  input  logic [REG_ADDR_W-1:0] query_rt_i,
  output mdq_entry_t            head_o,
  output logic [MDQ_CNT_W-1:0]  count_o,
  output logic                  pend_rs_o,
  output logic                  pend_rt_o
);

  mdq_entry_t [MDQ_DEPTH-1:0] ent_q;
  mdq_entry_t [MDQ_DEPTH-1:0] ent_d;
  mdq_entry_t [MDQ_DEPTH-1:0] ent_k;
  mdq_entry_t                 new_ent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  // Kill only entries already queued, then shift on pop, then append.
  always_comb begin
    ent_k         = ent_q;
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.rd    = push_rd_i;
    new_ent.data  = push_data_i;
    for (int i = 0; i < int'(MDQ_DEPTH); i++) begin
      if (kill_en_i && ent_q[i].valid && (ent_q[i].rd == kill_addr_i)) begin
        ent_k[i].kill = 1'b1;
      end
    end
    ent_d = ent_k;
    if (pop_i) begin
      ent_d[0] = ent_k[1];
      ent_d[1] = '0;
    end
    if (push_i) begin
      if (!ent_d[0].valid) begin
        ent_d[0] = new_ent;
      end else begin
        ent_d[1] = new_ent;
      end
    end
  end

  assign head_o    = ent_q[0];
  assign count_o   = MDQ_CNT_W'(ent_q[0].valid) + MDQ_CNT_W'(ent_q[1].valid);
  assign pend_rs_o = entry_pending(ent_q[0], query_rs_i) || entry_pending(ent_q[1], query_rs_i);
  assign pend_rt_o = entry_pending(ent_q[0], query_rt_i) || entry_pending(ent_q[1], query_rt_i);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline WB stage
// and queued mul/div results, with a starvation guard for the queue head.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_port_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned FORCE_AT = (STARVE_LIMIT > 1) ? (STARVE_LIMIT - 1) : 1;

  mdq_entry_t            head;
  logic [MDQ_CNT_W-1:0]  count;
  logic                  q_pend_rs;
  logic                  q_pend_rt;

  logic [CNT_W-1:0]      starve_q;
  logic [CNT_W-1:0]      starve_d;
  logic [CNT_W-1:0]      starve_inc;
  logic                  force_q;
  logic                  force_d;

  grant_e                gnt;
  logic                  pipe_live;
  logic                  head_pop;
  logic                  md_ready_c;
  logic                  push;

  assign pipe_live = bus.RegWrite_WB && (bus.WriteReg_WB != '0);

  // Grant priority: forced head, then live pipeline, then any queued head.
  always_comb begin
    gnt = GNT_IDLE;
    if (!rst_n) begin
      gnt = GNT_IDLE;
    end else if (force_q && head.valid) begin
      gnt = GNT_HEAD;
    end else if (pipe_live) begin
      gnt = GNT_PIPE;
    end else if (head.valid) begin
      gnt = GNT_HEAD;
    end
  end

  assign head_pop   = (gnt == GNT_HEAD);
  assign md_ready_c = rst_n && ((count < MDQ_CNT_W'(2)) || head_pop);
  assign push       = bus.md_valid && md_ready_c && (bus.md_rd != '0);

  wb_md_queue u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_rd_i   (bus.md_rd),
    .push_data_i (bus.md_data),
    .pop_i       (head_pop),
    .kill_en_i   (gnt == GNT_PIPE),
    .kill_addr_i (bus.WriteReg_WB),
    .query_rs_i  (bus.query_rs),
    .query_rt_i  (bus.query_rt),
    .head_o      (head),
    .count_o     (count),
    .pend_rs_o   (q_pend_rs),
    .pend_rt_o   (q_pend_rt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      force_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      force_q  <= force_d;
    end
  end

  assign starve_inc = starve_q + CNT_W'(1);

  // Head waits are counted while it sits unpopped; force arms on the limit.
  always_comb begin
    starve_d = starve_q;
    force_d  = force_q;
    if (head_pop || !head.valid) begin
      starve_d = '0;
    end else begin
      starve_d = starve_inc;
    end
    if (head_pop) begin
      force_d = 1'b0;
    end else if (head.valid && (starve_inc >= CNT_W'(FORCE_AT))) begin
      force_d = 1'b1;
    end
  end

  // Write-port drive; a killed head drains silently like an idle cycle.
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (gnt == GNT_PIPE) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.WriteReg_WB;
      bus.rf_wdata = bus.WriteReg_Data_WB;
    end else if (head_pop && !head.kill) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = head.rd;
      bus.rf_wdata = head.data;
    end
  end

  assign bus.md_ready = md_ready_c;
  assign bus.stall_wb = rst_n && force_q && pipe_live;
  assign bus.pend_rs  = rst_n && q_pend_rs;
  assign bus.pend_rt  = rst_n && q_pend_rt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: each driven cycle queues its expected
// port outputs, which are popped and compared on the following falling edge.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        stall;
    logic        rdy;
    logic        prs;
    logic        prt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rf_model [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, queue the outputs this cycle must show.
  task automatic cyc(input string tag, input int rst,
                     input int pw, input int prd, input int pd,
                     input int mv, input int mrd, input int md,
                     input int qrs, input int qrt,
                     input int ewe, input int ewa, input int ewd,
                     input int est, input int erdy, input int eprs, input int eprt);
    exp_t e;
    rst_n                = 1'(rst);
    bus.RegWrite_WB      = 1'(pw);
    bus.WriteReg_WB      = 5'(prd);
    bus.WriteReg_Data_WB = 32'(pd);
    bus.md_valid         = 1'(mv);
    bus.md_rd            = 5'(mrd);
    bus.md_data          = 32'(md);
    bus.query_rs         = 5'(qrs);
    bus.query_rt         = 5'(qrt);
    e.tag   = tag;
    e.we    = 1'(ewe);
    e.wa    = 5'(ewa);
    e.wd    = 32'(ewd);
    e.stall = 1'(est);
    e.rdy   = 1'(erdy);
    e.prs   = 1'(eprs);
    e.prt   = 1'(eprt);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk({mon_e.tag, ".we"},    32'(bus.rf_we),    32'(mon_e.we));
      chk({mon_e.tag, ".waddr"}, 32'(bus.rf_waddr), 32'(mon_e.wa));
      chk({mon_e.tag, ".wdata"}, bus.rf_wdata,      mon_e.wd);
      chk({mon_e.tag, ".stall"}, 32'(bus.stall_wb), 32'(mon_e.stall));
      chk({mon_e.tag, ".ready"}, 32'(bus.md_ready), 32'(mon_e.rdy));
      chk({mon_e.tag, ".prs"},   32'(bus.pend_rs),  32'(mon_e.prs));
      chk({mon_e.tag, ".prt"},   32'(bus.pend_rt),  32'(mon_e.prt));
      if (bus.rf_we === 1'b1) rf_model[bus.rf_waddr] = bus.rf_wdata;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
    bus.RegWrite_WB = 1'b0; bus.WriteReg_WB = '0; bus.WriteReg_Data_WB = '0;
    bus.md_valid = 1'b0; bus.md_rd = '0; bus.md_data = '0;
    bus.query_rs = '0; bus.query_rt = '0;
    @(posedge clk);
    #1;

    // Reset holds every output low even with live requests.
    cyc("rst0", 0, 1,1,'h1,  1,7,'h2,  7,1,  0,0,0,  0,0,0,0);
    cyc("rst1", 0, 1,1,'h1,  1,7,'h2,  7,1,  0,0,0,  0,0,0,0);

    // Single md result with idle pipeline.
    cyc("a_acc",  1, 0,0,0,  1,7,'h11,  7,0,  0,0,0,      0,1,0,0);
    cyc("a_wr",   1, 0,0,0,  0,0,0,     7,0,  1,7,'h11,   0,1,1,0);
    cyc("a_idle", 1, 0,0,0,  0,0,0,     7,0,  0,0,0,      0,1,0,0);

    // Pipeline hogs the port; head r9 forced on the 4th cycle.
    cyc("b0",       1, 1,3,'h30,  1,9,'h99,  9,9,  1,3,'h30,  0,1,0,0);
    cyc("b1",       1, 1,3,'h31,  0,0,0,     9,9,  1,3,'h31,  0,1,1,1);
    cyc("b2",       1, 1,3,'h32,  0,0,0,     9,9,  1,3,'h32,  0,1,1,1);
    cyc("b3",       1, 1,3,'h33,  0,0,0,     9,9,  1,3,'h33,  0,1,1,1);
    cyc("b_force",  1, 1,3,'h34,  0,0,0,     9,9,  1,9,'h99,  1,1,1,1);
    cyc("b_resume", 1, 1,3,'h34,  0,0,0,     9,9,  1,3,'h34,  0,1,0,0);
    cyc("b_idle",   1, 0,0,0,     0,0,0,     9,9,  0,0,0,     0,1,0,0);

    // Full queue backpressure until the forced pop, with enqueue on pop.
    cyc("c0",      1, 1,4,'h40,  1,10,'hA0,  10,11,  1,4,'h40,   0,1,0,0);
    cyc("c1",      1, 1,4,'h40,  1,11,'hB0,  10,11,  1,4,'h40,   0,1,1,0);
    cyc("c_full2", 1, 1,4,'h40,  1,12,'hC0,  10,11,  1,4,'h40,   0,0,1,1);
    cyc("c_full3", 1, 1,4,'h40,  1,12,'hC0,  10,11,  1,4,'h40,   0,0,1,1);
    cyc("c_force", 1, 1,4,'h40,  1,12,'hC0,  10,11,  1,10,'hA0,  1,1,1,1);
    cyc("c5",      1, 1,4,'h40,  0,0,0,      11,12,  1,4,'h40,   0,0,1,1);
    cyc("c6",      1, 0,0,0,     0,0,0,      11,12,  1,11,'hB0,  0,1,1,1);
    cyc("c7",      1, 0,0,0,     0,0,0,      11,12,  1,12,'hC0,  0,1,0,1);
    cyc("c_idle",  1, 0,0,0,     0,0,0,      11,12,  0,0,0,      0,1,0,0);

    // Younger pipeline write to r5 kills the queued r5 result.
    cyc("d0",     1, 0,0,0,     1,5,'hAA,  5,0,  0,0,0,     0,1,0,0);
    cyc("d_kill", 1, 1,5,'hBB,  0,0,0,     5,0,  1,5,'hBB,  0,1,1,0);
    cyc("d_pend", 1, 1,6,'h66,  0,0,0,     5,6,  1,6,'h66,  0,1,0,0);
    cyc("d_pop",  1, 0,0,0,     0,0,0,     5,0,  0,0,0,     0,1,0,0);
    cyc("d_idle", 1, 0,0,0,     0,0,0,     5,0,  0,0,0,     0,1,0,0);

    // Same-cycle enqueue with matching rd survives.
    cyc("e0",       1, 1,8,'h80,  1,8,'h81,  8,0,  1,8,'h80,  0,1,0,0);
    cyc("e_nokill", 1, 0,0,0,     0,0,0,     8,0,  1,8,'h81,  0,1,1,0);
    cyc("e_idle",   1, 0,0,0,     0,0,0,     8,0,  0,0,0,     0,1,0,0);

    // Write to r0 is not live; md_rd=0 is accepted and dropped.
    cyc("f0",     1, 1,0,'hFF,  1,13,'hD0,  13,0,  0,0,0,      0,1,0,0);
    cyc("f_zero", 1, 1,0,'hFF,  0,0,0,      13,0,  1,13,'hD0,  0,1,1,0);
    cyc("f_rd0",  1, 0,0,0,     1,0,'h55,   0,0,   0,0,0,      0,1,0,0);
    cyc("f_drop", 1, 0,0,0,     0,0,0,      0,0,   0,0,0,      0,1,0,0);

    // Reset with a full queue and force armed drops everything.
    cyc("g0",     1, 1,2,'h20,  1,14,'hE0,  14,15,  1,2,'h20,  0,1,0,0);
    cyc("g1",     1, 1,2,'h20,  1,15,'hF0,  14,15,  1,2,'h20,  0,1,1,0);
    cyc("g2",     1, 1,2,'h20,  0,0,0,      14,15,  1,2,'h20,  0,0,1,1);
    cyc("g3",     1, 1,2,'h20,  0,0,0,      14,15,  1,2,'h20,  0,0,1,1);
    cyc("g_rst0", 0, 1,2,'h20,  1,16,'h16,  14,15,  0,0,0,     0,0,0,0);
    cyc("g_rst1", 0, 1,2,'h20,  1,16,'h16,  14,15,  0,0,0,     0,0,0,0);
    cyc("g_post0",1, 0,0,0,     0,0,0,      14,15,  0,0,0,     0,1,0,0);
    cyc("g_post1",1, 0,0,0,     0,0,0,      14,15,  0,0,0,     0,1,0,0);
    cyc("g_pipe", 1, 1,2,'h21,  0,0,0,      14,15,  1,2,'h21,  0,1,0,0);
    cyc("g_end",  1, 0,0,0,     0,0,0,      14,15,  0,0,0,     0,1,0,0);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("r5_final",   rf_model[5],    32'hBB);
    chk("r8_final",   rf_model[8],    32'h81);
    chk("r9_final",   rf_model[9],    32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
